// File: rtl/cpu_sram_arbiter_pkg.sv
// rtl/cpu_sram_arbiter_pkg.sv - shared constants and types for the CPU SRAM-like port arbiter
package cpu_sram_arbiter_pkg;

   localparam logic REQ_INST = 1'b0;
   localparam logic REQ_DATA = 1'b1;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_LOCK_INST = 2'd1,
      ST_LOCK_DATA = 2'd2
   } lock_state_t;

endpackage

// File: rtl/arb_id_fifo.sv
// rtl/arb_id_fifo.sv - in-order requester ID FIFO used to route responses
module arb_id_fifo #(
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   push,
   input  logic                   push_id,
   input  logic                   pop,
   output logic [$clog2(DEPTH):0] count,
   output logic                   head_id
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [DEPTH-1:0] slots;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
      return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
   endfunction

   // Full is judged on the count before this cycle's pop, so no bypass when full.
   assign do_push = push & (count < CNT_W'(DEPTH));
   assign do_pop  = pop & (count != '0);
   assign head_id = slots[rd_ptr];

   always_ff @(posedge clk) begin
      if (!resetn) begin
         slots  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            slots[wr_ptr] <= push_id;
            wr_ptr        <= ptr_next(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= ptr_next(rd_ptr);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/cpu_sram_arbiter.sv
// rtl/cpu_sram_arbiter.sv - data-priority arbiter sharing one SRAM-like port between fetch and load/store
module cpu_sram_arbiter
   import cpu_sram_arbiter_pkg::*;
#(
   parameter int MAX_OUTST = 2,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32
) (
   input  logic              clk,
   input  logic              resetn,

   input  logic              inst_req,
   input  logic              inst_wr,
   input  logic [1:0]        inst_size,
   input  logic [ADDR_W-1:0] inst_addr,
   input  logic [3:0]        inst_wstrb,
   input  logic [DATA_W-1:0] inst_wdata,
   output logic              inst_addr_ok,
   output logic              inst_data_ok,
   output logic [DATA_W-1:0] inst_rdata,

   input  logic              data_req,
   input  logic              data_wr,
   input  logic [1:0]        data_size,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [3:0]        data_wstrb,
   input  logic [DATA_W-1:0] data_wdata,
   output logic              data_addr_ok,
   output logic              data_data_ok,
   output logic [DATA_W-1:0] data_rdata,

   output logic              mem_req,
   output logic              mem_wr,
   output logic [1:0]        mem_size,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_wstrb,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_addr_ok,
   input  logic              mem_data_ok,
   input  logic [DATA_W-1:0] mem_rdata,

   output logic              proto_err
);

   localparam int CNT_W = $clog2(MAX_OUTST) + 1;

   lock_state_t      state_q;
   lock_state_t      state_d;
   logic             sel_id;
   logic             sel_req;
   logic             can_push;
   logic             has_entry;
   logic             handshake;
   logic             resp_pop;
   logic             head_id;
   logic [CNT_W-1:0] count;

   assign can_push  = count < CNT_W'(MAX_OUTST);
   assign has_entry = count != '0;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // A lock pins the selection until the pending request is accepted or withdrawn.
   always_comb begin
      sel_id  = REQ_INST;
      sel_req = 1'b0;
      state_d = ST_IDLE;
      case (state_q)
         ST_LOCK_INST: begin
            sel_id  = REQ_INST;
            sel_req = inst_req;
         end
         ST_LOCK_DATA: begin
            sel_id  = REQ_DATA;
            sel_req = data_req;
         end
         default: begin
            if (data_req) begin
               sel_id  = REQ_DATA;
               sel_req = 1'b1;
            end else if (inst_req) begin
               sel_id  = REQ_INST;
               sel_req = 1'b1;
            end
         end
      endcase

      mem_req = resetn & sel_req & can_push;
      if (mem_req && !mem_addr_ok) begin
         state_d = (sel_id == REQ_DATA) ? ST_LOCK_DATA : ST_LOCK_INST;
      end
   end

   assign mem_wr    = (sel_id == REQ_DATA) ? data_wr    : inst_wr;
   assign mem_size  = (sel_id == REQ_DATA) ? data_size  : inst_size;
   assign mem_addr  = (sel_id == REQ_DATA) ? data_addr  : inst_addr;
   assign mem_wstrb = (sel_id == REQ_DATA) ? data_wstrb : inst_wstrb;
   assign mem_wdata = (sel_id == REQ_DATA) ? data_wdata : inst_wdata;

   assign handshake    = mem_req & mem_addr_ok;
   assign inst_addr_ok = handshake & (sel_id == REQ_INST);
   assign data_addr_ok = handshake & (sel_id == REQ_DATA);

   assign resp_pop     = resetn & mem_data_ok & has_entry;
   assign inst_data_ok = resp_pop & (head_id == REQ_INST);
   assign data_data_ok = resp_pop & (head_id == REQ_DATA);
   assign inst_rdata   = mem_rdata;
   assign data_rdata   = mem_rdata;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         proto_err <= 1'b0;
      end else if (mem_data_ok && !has_entry) begin
         proto_err <= 1'b1;
      end
   end

   arb_id_fifo #(
      .DEPTH (MAX_OUTST)
   ) u_id_fifo (
      .clk     (clk),
      .resetn  (resetn),
      .push    (handshake),
      .push_id (sel_id),
      .pop     (resp_pop),
      .count   (count),
      .head_id (head_id)
   );

endmodule

// File: tb/tb_cpu_sram_arbiter.sv
// tb/tb_cpu_sram_arbiter.sv - self-checking bench for cpu_sram_arbiter
module tb_cpu_sram_arbiter;

   localparam int MAX = 2;
   localparam logic [31:0] IADDR = 32'h1c000100;
   localparam logic [31:0] DADDR = 32'h00000040;

   logic        clk;
   logic        resetn;
   logic        inst_req, inst_wr, data_req, data_wr;
   logic [1:0]  inst_size, data_size;
   logic [31:0] inst_addr, data_addr, inst_wdata, data_wdata;
   logic [3:0]  inst_wstrb, data_wstrb;
   logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
   logic [31:0] inst_rdata, data_rdata;
   logic        mem_req, mem_wr;
   logic [1:0]  mem_size;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_addr_ok, mem_data_ok;
   logic [31:0] mem_rdata;
   logic        proto_err;

   int errors = 0;
   int checks = 0;

   int q[$];
   int lock_to = -1;
   bit perr = 1'b0;

   cpu_sram_arbiter #(.MAX_OUTST(MAX), .ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .resetn(resetn),
      .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
      .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
      .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
      .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
      .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
      .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
      .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .proto_err(proto_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: pending-accept queue of requester IDs, plus which requester (if any) is stuck waiting.
   task automatic step();
      int  sel;
      bit  sreq, mreq, pop, push;
      @(negedge clk);
      sel  = 0;
      sreq = 1'b0;
      if (lock_to >= 0) begin
         sel  = lock_to;
         sreq = (sel == 1) ? data_req : inst_req;
      end else if (data_req) begin
         sel  = 1;
         sreq = 1'b1;
      end else if (inst_req) begin
         sel  = 0;
         sreq = 1'b1;
      end
      mreq = resetn && sreq && (q.size() < MAX);
      push = mreq && mem_addr_ok;
      pop  = resetn && mem_data_ok && (q.size() > 0);

      chk("mem_req", 32'(mem_req), 32'(mreq));
      chk("inst_addr_ok", 32'(inst_addr_ok), 32'(push && sel == 0));
      chk("data_addr_ok", 32'(data_addr_ok), 32'(push && sel == 1));
      chk("inst_data_ok", 32'(inst_data_ok), 32'(pop && q[0] == 0));
      chk("data_data_ok", 32'(data_data_ok), 32'(pop && q[0] == 1));
      chk("proto_err", 32'(proto_err), 32'(perr));
      chk("inst_rdata", inst_rdata, mem_rdata);
      chk("data_rdata", data_rdata, mem_rdata);
      if (mreq) begin
         chk("mem_addr", mem_addr, (sel == 1) ? data_addr : inst_addr);
         chk("mem_wr", 32'(mem_wr), 32'((sel == 1) ? data_wr : inst_wr));
         chk("mem_size", 32'(mem_size), 32'((sel == 1) ? data_size : inst_size));
         chk("mem_wstrb", 32'(mem_wstrb), 32'((sel == 1) ? data_wstrb : inst_wstrb));
         chk("mem_wdata", mem_wdata, (sel == 1) ? data_wdata : inst_wdata);
      end

      if (!resetn) begin
         q.delete();
         lock_to = -1;
         perr    = 1'b0;
      end else begin
         if (mem_data_ok && q.size() == 0) perr = 1'b1;
         if (pop) void'(q.pop_front());
         if (push) q.push_back(sel);
         lock_to = (mreq && !mem_addr_ok) ? sel : -1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set(input bit ir, input bit dr, input bit aok, input bit dok, input logic [31:0] rd);
      inst_req    = ir;
      data_req    = dr;
      mem_addr_ok = aok;
      mem_data_ok = dok;
      mem_rdata   = rd;
      #2;
   endtask

   initial begin
      resetn     = 1'b0;
      inst_wr    = 1'b0;  inst_size = 2'd2; inst_addr = IADDR;
      inst_wstrb = 4'h0;  inst_wdata = 32'h0;
      data_wr    = 1'b1;  data_size = 2'd1; data_addr = DADDR;
      data_wstrb = 4'b0011; data_wdata = 32'hdeadbeef;

      set(1, 1, 0, 0, 0);
      chk("reset_mem_req", 32'(mem_req), 32'd0);
      step();
      set(1, 1, 1, 0, 0);
      step();

      resetn = 1'b1;
      set(1, 1, 1, 0, 0);
      chk("prio_addr", mem_addr, 32'h00000040);
      chk("prio_daok", 32'(data_addr_ok), 32'd1);
      chk("prio_iaok", 32'(inst_addr_ok), 32'd0);
      step();
      set(1, 0, 1, 0, 0);
      chk("second_addr", mem_addr, 32'h1c000100);
      chk("second_iaok", 32'(inst_addr_ok), 32'd1);
      step();
      set(1, 1, 1, 1, 32'h22222222);
      chk("full_mem_req", 32'(mem_req), 32'd0);
      chk("full_ddok", 32'(data_data_ok), 32'd1);
      chk("full_drdata", data_rdata, 32'h22222222);
      step();
      set(1, 0, 1, 1, 32'h11111111);
      chk("simul_iaok", 32'(inst_addr_ok), 32'd1);
      chk("simul_idok", 32'(inst_data_ok), 32'd1);
      step();
      set(0, 0, 0, 1, 32'h11111111);
      chk("drain_idok", 32'(inst_data_ok), 32'd1);
      step();

      set(1, 0, 0, 0, 0);
      step();
      set(1, 1, 0, 0, 0);
      chk("lock_addr", mem_addr, 32'h1c000100);
      chk("lock_daok", 32'(data_addr_ok), 32'd0);
      step();
      set(1, 1, 0, 0, 0);
      step();
      set(1, 1, 1, 0, 0);
      chk("lock_accept", 32'(inst_addr_ok), 32'd1);
      step();
      set(0, 1, 1, 0, 0);
      chk("after_lock_daok", 32'(data_addr_ok), 32'd1);
      step();

      set(0, 0, 0, 1, 32'h11111111);
      chk("route_idok", 32'(inst_data_ok), 32'd1);
      chk("route_ddok0", 32'(data_data_ok), 32'd0);
      step();
      set(0, 0, 0, 1, 32'h22222222);
      chk("route_ddok", 32'(data_data_ok), 32'd1);
      step();

      set(1, 0, 0, 0, 0);
      step();
      set(0, 0, 0, 0, 0);
      chk("drop_mem_req", 32'(mem_req), 32'd0);
      step();
      set(0, 1, 1, 0, 0);
      chk("drop_then_daok", 32'(data_addr_ok), 32'd1);
      step();
      set(0, 0, 0, 1, 32'h00000033);
      step();

      set(0, 0, 0, 1, 32'h00000044);
      chk("perr_no_idok", 32'(inst_data_ok), 32'd0);
      chk("perr_no_ddok", 32'(data_data_ok), 32'd0);
      step();
      set(0, 0, 0, 0, 0);
      chk("perr_set", 32'(proto_err), 32'd1);
      step();
      step();
      set(0, 0, 0, 0, 0);
      chk("perr_sticky", 32'(proto_err), 32'd1);
      step();

      set(1, 0, 1, 0, 0);
      step();
      resetn = 1'b0;
      set(0, 0, 0, 0, 0);
      step();
      resetn = 1'b1;
      set(0, 0, 0, 0, 0);
      chk("perr_cleared", 32'(proto_err), 32'd0);
      step();
      set(0, 0, 0, 1, 32'h00000055);
      chk("abandoned_idok", 32'(inst_data_ok), 32'd0);
      step();
      set(0, 0, 0, 0, 0);
      chk("abandoned_perr", 32'(proto_err), 32'd1);
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
